// File: rtl/sort_cmd_driver.sv
// ---------------------------------------------------------------------------
// sort_cmd_driver
//
// Host-side command driver for the toggle-command insertion sorter.
// A job arrives as a valid/ready stream of values terminated by s_last. The
// driver clears the sorter, pushes each value, triggers a sort, then pops the
// sorter until it is empty and presents every popped value on a valid/ready
// output stream. It is the only agent driving the sorter command lines.
//
// Commands are toggles: every level change on push/pop/clear/sort is one
// command. After each toggle the driver waits GUARD enabled cycles and then
// for sorter idle before doing anything else, so exactly one command is ever
// in flight.
//
// Handshake semantics (both streams): a beat transfers on an enabled rising
// clock edge where valid && ready are both high. A producer holds valid and
// payload stable until the transfer. s_ready and m_valid are decodes of
// registered state (plus sorter idle for s_ready); neither depends on s_valid
// or m_ready combinationally.
//
// Parameters
//   W      data width, must match the sorter data width
//   GUARD  enabled cycles to wait after a toggle before sampling idle (>= 3)
//
// Ports
//   clk, rstn      clock (rising edge), async active-low reset shared with
//                  the sorter
//   enable         clock enable; low freezes all state and outputs
//   s_valid/s_ready/s_data/s_last   job input stream
//   m_valid/m_ready/m_data/m_last   popped-value output stream; m_last marks
//                  the value after which the sorter reported empty
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle pulse on the cycle after the final output beat
//                  (or after a job that left nothing to pop)
//   overflow       sticky: a beat was dropped because the sorter was full;
//                  cleared when the next job starts
//   push/pop/clear/sort  toggle commands to the sorter
//   din            push data, stable from the push toggle to the next push
//   dout           sorter pop data, valid once idle after a pop
//   idle/full/empty      sorter status
// ---------------------------------------------------------------------------
module sort_cmd_driver #(
    parameter int W     = 16,
    parameter int GUARD = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enable,
    // job input stream
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    // result output stream
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    // status
    output logic         busy,
    output logic         done,
    output logic         overflow,
    // sorter command side
    output logic         push,
    output logic         pop,
    output logic         clear,
    output logic         sort,
    output logic [W-1:0] din,
    input  logic [W-1:0] dout,
    input  logic         idle,
    input  logic         full,
    input  logic         empty
);

    localparam int            GW       = $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_PRESENT = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;       // where WAIT goes once the sorter is idle
    logic [GW-1:0] guard_q, guard_d;
    logic          sort_pend_q, sort_pend_d;  // s_last seen, sort still to issue

    logic          push_d, pop_d, clear_d, sort_d;
    logic [W-1:0]  din_d;
    logic          m_valid_d, m_last_d;
    logic [W-1:0]  m_data_d;
    logic          done_d, overflow_d;

    // Input beats are only taken in LOAD once the last command has settled.
    // Once the final beat is in, no more beats are accepted: the sort must go
    // out first and the job is then owned by the unload phase.
    assign s_ready = (state_q == ST_LOAD) && !sort_pend_q && (guard_q == '0) && idle;
    assign busy    = (state_q != ST_IDLE);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        guard_d     = guard_q;
        sort_pend_d = sort_pend_q;
        push_d      = push;
        pop_d       = pop;
        clear_d     = clear;
        sort_d      = sort;
        din_d       = din;
        m_valid_d   = m_valid;
        m_data_d    = m_data;
        m_last_d    = m_last;
        done_d      = 1'b0;
        overflow_d  = overflow;

        case (state_q)
            ST_IDLE: begin
                // The first beat of a job is left pending on the input; it is
                // accepted in LOAD after the sorter has been cleared.
                if (s_valid) begin
                    overflow_d = 1'b0;
                    clear_d    = ~clear;
                    guard_d    = GUARD_LD;
                    ret_d      = ST_LOAD;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The guard covers the sorter's toggle synchroniser, so idle is
                // only trusted after it has had time to drop for this command.
                if (guard_q != '0) begin
                    guard_d = guard_q - GW'(1);
                end else if (idle) begin
                    state_d = ret_q;
                end
            end

            ST_LOAD: begin
                if (sort_pend_q) begin
                    if (idle) begin
                        sort_d      = ~sort;
                        sort_pend_d = 1'b0;
                        guard_d     = GUARD_LD;
                        ret_d       = ST_UNLOAD;
                        state_d     = ST_WAIT;
                    end
                end else if (s_valid && s_ready) begin
                    sort_pend_d = s_last;
                    if (full) begin
                        // No room: drop the beat, remember it, stay in LOAD.
                        overflow_d = 1'b1;
                    end else begin
                        din_d   = s_data;
                        push_d  = ~push;
                        guard_d = GUARD_LD;
                        ret_d   = ST_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_UNLOAD: begin
                if (empty) begin
                    state_d = ST_DRAIN;
                end else begin
                    pop_d   = ~pop;
                    guard_d = GUARD_LD;
                    ret_d   = ST_CAPTURE;
                    state_d = ST_WAIT;
                end
            end

            ST_CAPTURE: begin
                // empty now reflects the sorter after this pop, so it flags
                // the final value of the job.
                m_data_d  = dout;
                m_last_d  = empty;
                m_valid_d = 1'b1;
                state_d   = ST_PRESENT;
            end

            ST_PRESENT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_UNLOAD;
                    end
                end
            end

            ST_DRAIN: begin
                // Every beat was dropped: nothing to pop, just finish the job.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers. Everything holds while enable is low,
    // including the one-cycle done pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            guard_q     <= '0;
            sort_pend_q <= 1'b0;
            push        <= 1'b0;
            pop         <= 1'b0;
            clear       <= 1'b0;
            sort        <= 1'b0;
            din         <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            guard_q     <= guard_d;
            sort_pend_q <= sort_pend_d;
            push        <= push_d;
            pop         <= pop_d;
            clear       <= clear_d;
            sort        <= sort_d;
            din         <= din_d;
            m_valid     <= m_valid_d;
            m_data      <= m_data_d;
            m_last      <= m_last_d;
            done        <= done_d;
            overflow    <= overflow_d;
        end
    end

endmodule

// File: doc/sort_cmd_driver.md
# sort_cmd_driver

Host-side command driver for the toggle-command insertion sorter. It accepts a job of values on a valid/ready input stream, clears and loads the sorter through toggle commands, and triggers the sort. It then pops every stored value back out onto a valid/ready output stream. It sits between a streaming source/sink and the sorter and is the only agent driving the sorter's command lines.

## Interface
- W, 16, data width (must equal sorter data width)
- GUARD, 3, enabled cycles to wait after any command toggle before sampling sorter `idle` (minimum 3)
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low; shared with the sorter
- enable  in  1  clock enable; low freezes all state and outputs (same net as sorter enable)
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  W  value to load
- s_last  in  1  marks final beat of a job
- m_valid  out  1  output beat valid
- m_ready  in  1  sink accepts when m_valid && m_ready
- m_data  out  W  popped value
- m_last  out  1  final popped value of the job (sorter empty after this pop)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the cycle after the m_last handshake
- overflow  out  1  sticky: a beat arrived while sorter `full`; cleared at next job start
- push, pop, clear, sort  out  1 each  toggle commands to sorter; every level change is one command
- din  out  W  push data to sorter, stable from push toggle until next push
- dout  in  W  sorter pop data, valid when sorter idle after pop
- idle, full, empty  in  1 each  sorter status

## Operation
- Reset: all outputs 0; state IDLE; guard counter 0.
- Command issue: invert exactly one toggle line, load guard counter with GUARD, enter WAIT. WAIT decrements guard each enabled cycle; at guard==0 and idle==1 it proceeds to the return state. Never more than one toggle in flight.
- States:
  - IDLE: s_ready=0. On s_valid, clear overflow, toggle clear, WAIT -> LOAD.
  - LOAD: s_ready=1 only when guard==0 and idle==1.
    - Handshake with full==0: din<=s_data, toggle push, WAIT.
    - Handshake with full==1: beat discarded, overflow<=1, no toggle.
    - After an s_last beat (pushed or discarded): toggle sort, WAIT -> UNLOAD.
  - UNLOAD: if empty==1, enter DRAIN_EMPTY. Otherwise toggle pop, WAIT -> CAPTURE.
  - CAPTURE: m_data<=dout, m_last<=empty, m_valid<=1 -> PRESENT.
  - PRESENT: hold m_valid/m_data/m_last stable until m_ready.
    - On handshake with m_last: done pulse -> IDLE.
    - On handshake otherwise: -> UNLOAD.
  - DRAIN_EMPTY: sorter empty after sort with no value to pop. Emits no beat; done pulse -> IDLE.
- Output order is the sorter's pop order; the driver does not reorder or compare values.
- s_valid without s_last is never terminated by the driver; the job stays in LOAD.

## Timing
- Toggle outputs are registered and change on the clock edge that enters WAIT.
- The sorter registers the toggle twice and leaves idle on the third enabled edge. GUARD>=3 guarantees that WAIT never samples the stale pre-command idle.
- Per-command cost is GUARD + sorter busy cycles. Push, pop and clear each cost 3+1 cycles minimum; sort cost depends on the data.
- Input throughput is at most one beat per (GUARD+1) cycles. Output latency from pop toggle to m_valid is GUARD+2 cycles minimum.
- s_ready and m_valid are registered-state decodes, with no combinational path from s_valid or m_ready.
- enable low: guard counter, FSM and toggles hold, and a pending handshake is not taken.
- Reset mid-job: toggles return to 0 asynchronously. The sorter must reset simultaneously (shared rstn), otherwise the 1->0 change is a spurious command.

## Test plan
- Basic job: beats 5, 3, 9, 1 (s_last on 1) against a behavioural sorter model -> one clear, four pushes, one sort, then m_data 9, 5, 3, 1 with m_last only on 1 and done one cycle after its handshake.
- Backpressure: same job with m_ready toggling at 1-in-3 -> m_data never changes while m_valid && !m_ready, and no extra pop toggles.
- Overflow: model full=1 after 2 pushes, send 4 beats -> overflow=1, only 2 push toggles, 2 output beats, overflow cleared at next job's first beat.
- Single beat: value 0xFFFF with s_last -> exactly one output beat 0xFFFF with m_last=1.
- Enable gating: drop enable for 10 cycles mid-LOAD and mid-PRESENT -> no toggle edges and outputs frozen during the gap; the result matches the basic job.
- Async reset during UNLOAD -> all outputs 0 immediately, state IDLE, and the next job completes correctly.
